// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a bank of two-state network nodes.
// Drives load/step strobes and reports meet point, attractor period and state.
module grn_attractor_ctrl #(
    parameter int N_NODES   = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vector,
    input  logic [N_NODES-1:0] icos_s0,
    input  logic [N_NODES-1:0] icos_s1,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    typedef enum logic [2:0] {IDLE, LOAD, MEET, PERIOD, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hcnt, pcnt;
    logic             same, hit, phit, h_max, p_max;

    assign same  = (icos_s0 == icos_s1);
    // Tortoise lags by exactly half the hare count only after an even number of pulses.
    assign hit   = (hcnt != '0) && !hcnt[0] && same;
    assign phit  = (pcnt != '0) && same;
    assign h_max = (hcnt == MAX_C);
    assign p_max = (pcnt == MAX_C);

    always_comb begin
        state_nxt = state;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LOAD;
            LOAD: begin
                reset_nos = 1'b1;
                state_nxt = MEET;
            end
            MEET: begin
                start_s0 = !hit && !h_max;
                start_s1 = !hit && !h_max;
                if (hit)        state_nxt = PERIOD;
                else if (h_max) state_nxt = DONE;
            end
            PERIOD: begin
                start_s1 = !phit && !p_max;
                if (phit || p_max) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hcnt       <= '0;
            pcnt       <= '0;
            init_state <= '0;
            timeout    <= 1'b0;
            meet_steps <= '0;
            period     <= '0;
            attractor  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                init_state <= init_vector;
                hcnt       <= '0;
                pcnt       <= '0;
                timeout    <= 1'b0;
                meet_steps <= '0;
                period     <= '0;
                attractor  <= '0;
            end
            if (state == MEET) begin
                if (start_s1) hcnt <= hcnt + 1'b1;
                if (hit) begin
                    meet_steps <= hcnt;
                    attractor  <= icos_s0;
                    pcnt       <= '0;
                end else if (h_max) begin
                    timeout <= 1'b1;
                    period  <= '0;
                end
            end
            if (state == PERIOD) begin
                if (start_s1) pcnt <= pcnt + 1'b1;
                if (phit) begin
                    period <= pcnt;
                end else if (p_max) begin
                    timeout <= 1'b1;
                    period  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Bench for grn_attractor_ctrl: node-bank model, per-cycle trace check from a
// latency/Floyd model, and literal result checks for the directed runs.
module tb_grn_attractor_ctrl;
    localparam int N = 4, W = 16;
    localparam int MAXS [2] = '{65535, 6};

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   start = '0;
    logic [N-1:0] iv [2];
    logic [N-1:0] s0 [2], s1 [2], ist [2], attr [2];
    logic         rn [2], ss0 [2], ss1 [2], bsy [2], dn [2], tmo [2];
    logic [W-1:0] ms [2], per [2];
    logic [1:0]   ph;
    bit           mode;

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(65535)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .init_vector(iv[0]),
        .icos_s0(s0[0]), .icos_s1(s1[0]), .reset_nos(rn[0]), .init_state(ist[0]),
        .start_s0(ss0[0]), .start_s1(ss1[0]), .busy(bsy[0]), .done(dn[0]),
        .timeout(tmo[0]), .meet_steps(ms[0]), .period(per[0]), .attractor(attr[0]));

    grn_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(6)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .init_vector(iv[1]),
        .icos_s0(s0[1]), .icos_s1(s1[1]), .reset_nos(rn[1]), .init_state(ist[1]),
        .start_s0(ss0[1]), .start_s1(ss1[1]), .busy(bsy[1]), .done(dn[1]),
        .timeout(tmo[1]), .meet_steps(ms[1]), .period(per[1]), .attractor(attr[1]));

    function automatic logic [N-1:0] nf(input logic [N-1:0] x, input bit m);
        return m ? {x[N-2:0], x[N-1]} : x;
    endfunction

    function automatic logic [N-1:0] iter(input logic [N-1:0] x, input bit m, input int n);
        logic [N-1:0] y = x;
        for (int i = 0; i < n; i++) y = nf(y, m);
        return y;
    endfunction

    // Node bank: hare steps on every start_s1, tortoise on odd-numbered start_s0 pulses.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                s0[d] <= '0; s1[d] <= '0; ph[d] <= 1'b0;
            end else if (rn[d]) begin
                s0[d] <= ist[d]; s1[d] <= ist[d]; ph[d] <= 1'b0;
            end else begin
                if (ss1[d]) s1[d] <= nf(s1[d], mode);
                if (ss0[d]) begin
                    if (!ph[d]) s0[d] <= nf(s0[d], mode);
                    ph[d] <= ~ph[d];
                end
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Expected run, filled by the stimulus before each start.
    int           eMh [2], ePp [2];
    bit           eMet [2], eTmo [2];
    logic [N-1:0] eAttr [2], eIv [2];
    int           go_cnt [2] = '{0, 0};
    int           abort_cnt = 0;
    bit           chk_en = 0;

    task automatic model(input int d, input logic [N-1:0] x, input bit m);
        eMet[d] = 0; eTmo[d] = 0; eMh[d] = MAXS[d]; ePp[d] = 0; eAttr[d] = '0; eIv[d] = x;
        for (int hc = 2; hc <= MAXS[d]; hc += 2)
            if (iter(x, m, hc / 2) == iter(x, m, hc)) begin
                eMet[d] = 1; eMh[d] = hc; eAttr[d] = iter(x, m, hc / 2);
                break;
            end
        if (!eMet[d]) eTmo[d] = 1;
        else begin
            eTmo[d] = 1; ePp[d] = MAXS[d];
            for (int p = 1; p <= MAXS[d]; p++)
                if (iter(eAttr[d], m, p) == eAttr[d]) begin
                    eTmo[d] = 0; ePp[d] = p;
                    break;
                end
        end
    endtask

    // Compare process state
    bit           act [2] = '{0, 0};
    int           cyc [2], go_seen [2] = '{0, 0}, ndone [2] = '{0, 0};
    int           abort_seen = 0;
    bit           hold_ok [2] = '{1, 1}, hm_m [2] = '{1, 1}, hm_p [2] = '{1, 1};
    logic         hv_tmo [2] = '{0, 0};
    logic [W-1:0] hv_per [2] = '{0, 0}, hv_meet [2] = '{0, 0};
    logic [N-1:0] hv_attr [2] = '{0, 0};

    task automatic chk_res(input int d);
        chk($sformatf("d%0d_timeout", d), 32'(tmo[d]), 32'(hv_tmo[d]));
        if (hm_p[d]) chk($sformatf("d%0d_period", d), 32'(per[d]), 32'(hv_per[d]));
        if (hm_m[d]) begin
            chk($sformatf("d%0d_meet_steps", d), 32'(ms[d]), 32'(hv_meet[d]));
            chk($sformatf("d%0d_attractor", d), 32'(attr[d]), 32'(hv_attr[d]));
        end
    endtask

    always @(negedge clk) begin
        if (abort_seen != abort_cnt) begin
            abort_seen = abort_cnt;
            for (int d = 0; d < 2; d++) begin
                act[d] = 0; hold_ok[d] = 1; hm_m[d] = 1; hm_p[d] = 1;
                hv_tmo[d] = 0; hv_per[d] = '0; hv_meet[d] = '0; hv_attr[d] = '0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            logic e_rn, e_s0, e_s1, e_b, e_dn;
            if (go_seen[d] != go_cnt[d]) begin
                go_seen[d] = go_cnt[d]; act[d] = 1; cyc[d] = 0; hold_ok[d] = 0;
            end
            if (chk_en) begin
                e_rn = 0; e_s0 = 0; e_s1 = 0; e_b = 0; e_dn = 0;
                if (dn[d]) ndone[d]++;
                if (act[d]) begin
                    e_b = 1;
                    if (cyc[d] == 0) begin
                        e_rn = 1;
                        chk($sformatf("d%0d_init_state", d), 32'(ist[d]), 32'(eIv[d]));
                    end else if (cyc[d] <= eMh[d] + 1) begin
                        e_s0 = (cyc[d] - 1) < eMh[d]; e_s1 = e_s0;
                    end else if (cyc[d] <= eMh[d] + 1 + (eMet[d] ? ePp[d] + 1 : 0)) begin
                        e_s1 = (cyc[d] - 2 - eMh[d]) < ePp[d];
                    end else begin
                        e_dn = 1; act[d] = 0; hold_ok[d] = 1;
                        hm_m[d] = eMet[d]; hm_p[d] = !(eMet[d] && eTmo[d]);
                        hv_tmo[d] = eTmo[d]; hv_per[d] = eMet[d] ? W'(ePp[d]) : '0;
                        hv_meet[d] = W'(eMh[d]); hv_attr[d] = eAttr[d];
                        chk_res(d);
                    end
                    cyc[d]++;
                end else if (hold_ok[d]) chk_res(d);
                chk($sformatf("d%0d_reset_nos c%0d", d, cyc[d]), 32'(rn[d]), 32'(e_rn));
                chk($sformatf("d%0d_start_s0 c%0d", d, cyc[d]), 32'(ss0[d]), 32'(e_s0));
                chk($sformatf("d%0d_start_s1 c%0d", d, cyc[d]), 32'(ss1[d]), 32'(e_s1));
                chk($sformatf("d%0d_busy c%0d", d, cyc[d]), 32'(bsy[d]), 32'(e_b));
                chk($sformatf("d%0d_done c%0d", d, cyc[d]), 32'(dn[d]), 32'(e_dn));
            end
        end
    end

    task automatic launch(input int d, input logic [N-1:0] x, input bit m);
        model(d, x, m);
        mode = m; iv[d] = x;
        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0; go_cnt[d]++;
    endtask

    task automatic wait_done(input int d);
        bit got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (dn[d]) begin got = 1; break; end
        end
        if (!got) chk($sformatf("d%0d_done_wait", d), 0, 1);
    endtask

    task automatic lit(input int d, input int m_s, input int p, input logic [N-1:0] a, input bit t);
        chk("lit_meet_steps", 32'(ms[d]), 32'(m_s));
        chk("lit_period", 32'(per[d]), 32'(p));
        chk("lit_attractor", 32'(attr[d]), 32'(a));
        chk("lit_timeout", 32'(tmo[d]), 32'(t));
    endtask

    initial begin
        iv[0] = '0; iv[1] = '0; mode = 0;
        @(posedge clk); #1 chk_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_init_state", 32'(ist[0]), 0);
        chk("rst_meet_steps", 32'(ms[0]), 0);
        chk("rst_attractor", 32'(attr[1]), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // fixed-point network
        launch(0, 4'b1010, 0);
        wait_done(0);
        chk("model_fix_meet", eMh[0], 2);
        lit(0, 2, 1, 4'b1010, 0);
        repeat (3) @(posedge clk);

        // rotate-left, with an ignored start issued mid-run
        launch(0, 4'b0001, 1);
        repeat (3) @(posedge clk);
        #1 start[0] = 1'b1; iv[0] = 4'b1110;
        @(posedge clk); #1 start[0] = 1'b0; iv[0] = 4'b0001;
        wait_done(0);
        chk("model_rot_meet", eMh[0], 8);
        chk("model_rot_period", ePp[0], 4);
        lit(0, 8, 4, 4'b0001, 0);
        repeat (3) @(posedge clk);

        // rotate, all-zero state
        launch(0, 4'b0000, 1);
        wait_done(0);
        lit(0, 2, 1, 4'b0000, 0);
        repeat (3) @(posedge clk);

        // timeout instance: MAX_STEPS=6
        launch(1, 4'b0001, 1);
        wait_done(1);
        chk("lit_tmo_timeout", 32'(tmo[1]), 1);
        chk("lit_tmo_period", 32'(per[1]), 0);
        chk("model_tmo_pulses", eMh[1], 6);
        repeat (3) @(posedge clk);

        // start coincident with rst: rst wins
        #1 rst = 1'b1; start[0] = 1'b1; iv[0] = 4'b0101;
        @(posedge clk); #1 rst = 1'b0; start[0] = 1'b0; abort_cnt++;
        repeat (3) @(posedge clk);

        // abort mid-MEET, then rerun
        launch(0, 4'b0001, 1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 abort_cnt++;
        @(negedge clk);
        chk("abort_init_state", 32'(ist[0]), 0);
        chk("abort_meet_steps", 32'(ms[0]), 0);
        chk("abort_busy", 32'(bsy[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        launch(0, 4'b0001, 1);
        wait_done(0);
        lit(0, 8, 4, 4'b0001, 0);
        repeat (4) @(posedge clk);

        @(negedge clk);
        chk("done_count_d0", ndone[0], 4);
        chk("done_count_d1", ndone[1], 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
